// File: rtl/fetch_unit.sv
// fetch_unit: program counter, imem request sequencer and ir/imm capture.
// Define FETCH_ICOUNT_EN to add the icount output (captured ir words).
module fetch_unit #(
  parameter int BUS_WIDTH = 16,
  parameter int ADDR_W    = 8,
  parameter int IMEM_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 imem_read,
  input  logic                 imm_sel,
  input  logic                 pc_inc,
  input  logic                 jump,
  input  logic                 alu_zero,
  input  logic [BUS_WIDTH-1:0] imem_rdata,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic                 imem_en,
  output logic [BUS_WIDTH-1:0] ir,
  output logic [BUS_WIDTH-1:0] imm,
  output logic [ADDR_W-1:0]    pc,
  output logic                 busy,
  output logic                 pc_wrap,
`ifdef FETCH_ICOUNT_EN
  output logic [15:0]          icount,
`endif
  output logic                 overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE
  } state_t;

  localparam logic [1:0] CNT_LAST = 2'(IMEM_LAT - 1);

  state_t            state;
  state_t            state_n;
  logic [1:0]        cnt;
  logic [1:0]        cnt_n;
  logic              dest;
  logic              req;
  logic              cap;
  logic              ovr_set;
  logic              take_jump;
  logic              wrap_set;
  logic [ADDR_W-1:0] pc_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req     = 1'b0;
    cap     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (imem_read) begin
          req     = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_n   = '0;
        state_n = (IMEM_LAT == 1) ? S_CAPTURE : S_WAIT;
      end
      S_WAIT: begin
        cnt_n = cnt + 2'd1;
        if (cnt_n == CNT_LAST)
          state_n = S_CAPTURE;
      end
      S_CAPTURE: begin
        cap     = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy    = (state == S_ISSUE) || (state == S_WAIT);
  assign imem_en = enable && (state == S_ISSUE);
  assign ovr_set = imem_read && (state != S_IDLE);

  // jump target is the registered imm; a same-edge capture is not seen
  assign take_jump = jump && !alu_zero;

  always_comb begin
    pc_n     = pc;
    wrap_set = 1'b0;
    if (pc_inc) begin
      unique case (1'b1)
        take_jump: begin
          pc_n = imm[ADDR_W-1:0];
        end
        !take_jump: begin
          pc_n     = pc + ADDR_W'(1);
          wrap_set = &pc;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (enable) begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_addr <= '0;
      dest      <= 1'b0;
      ir        <= '0;
      imm       <= '0;
      pc        <= '0;
      pc_wrap   <= 1'b0;
      overrun   <= 1'b0;
    end else if (enable) begin
      pc <= pc_n;
      if (req) begin
        imem_addr <= pc;
        dest      <= imm_sel;
      end
      if (cap && !dest)
        ir <= imem_rdata;
      if (cap && dest)
        imm <= imem_rdata;
      if (wrap_set)
        pc_wrap <= 1'b1;
      if (ovr_set)
        overrun <= 1'b1;
    end
  end

`ifdef FETCH_ICOUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      icount <= '0;
    else if (enable && cap && !dest)
      icount <= icount + 16'd1;
  end
`endif

endmodule
